// File: rtl/sfifo_if.sv
`default_nettype none
// ============================================================================
// Module   : sfifo_if
// Brief    : Write/read handshake and status bundle of the sfifo block.
// Revision : 1.0
// ============================================================================
interface sfifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic [DATA_W-1:0] din;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   data_count;
    logic              overflow;
    logic              underflow;

    modport master (
        output din, wr_en, rd_en,
        input  dout, full, empty, almost_full, almost_empty,
               data_count, overflow, underflow
    );

    modport slave (
        input  din, wr_en, rd_en,
        output dout, full, empty, almost_full, almost_empty,
               data_count, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/sfifo.sv
`default_nettype none
// ============================================================================
// Module   : sfifo
// Brief    : Single-clock FIFO, standard or first-word-fall-through read,
//            with almost flags and one-cycle overflow/underflow pulses.
// Revision : 1.0
// ============================================================================
module sfifo #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 10,
    parameter bit FWFT      = 1'b0,
    parameter int AFULL_TH  = (1 << ADDR_W) - 4,
    parameter int AEMPTY_TH = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    sfifo_if.slave    bus
);

    localparam int                c_depth    = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   c_cnt_full = c_depth[ADDR_W:0];
    localparam logic [ADDR_W:0]   c_cnt_one  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   c_afull    = AFULL_TH[ADDR_W:0];
    localparam logic [ADDR_W:0]   c_aempty   = AEMPTY_TH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] c_ptr_one  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_q [c_depth];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic [DATA_W-1:0] dout_q,   dout_d;
    logic              ovf_q,    ovf_d;
    logic              udf_q,    udf_d;

    logic              w_full;
    logic              w_empty;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [ADDR_W-1:0] w_rd_ptr_inc;

    // Status is decoded from the registered count only, never from the requests.
    assign w_full       = (count_q == c_cnt_full);
    assign w_empty      = (count_q == '0);
    assign w_wr_acc     = bus.wr_en & ~w_full;
    assign w_rd_acc     = bus.rd_en & ~w_empty;
    assign w_rd_ptr_inc = rd_ptr_q + c_ptr_one;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = bus.wr_en & ~w_wr_acc;
        udf_d    = bus.rd_en & ~w_rd_acc;
        if (w_wr_acc) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
        end
        if (w_rd_acc) begin
            rd_ptr_d = w_rd_ptr_inc;
        end
        case ({w_wr_acc, w_rd_acc})
            2'b10:   count_d = count_q + c_cnt_one;
            2'b01:   count_d = count_q - c_cnt_one;
            default: count_d = count_q;
        endcase
    end

    generate
        if (FWFT) begin : g_fwft
            // dout always shows the head word; on a pop it moves to the next
            // stored word, or to din when the FIFO is (or becomes) otherwise empty.
            always_comb begin
                dout_d = dout_q;
                if (w_rd_acc) begin
                    if (count_q > c_cnt_one) begin
                        dout_d = mem_q[w_rd_ptr_inc];
                    end else if (w_wr_acc) begin
                        dout_d = bus.din;
                    end
                end else if (w_wr_acc && w_empty) begin
                    dout_d = bus.din;
                end
            end
        end else begin : g_std
            always_comb begin
                dout_d = dout_q;
                if (w_rd_acc) begin
                    dout_d = mem_q[rd_ptr_q];
                end
            end
        end
    endgenerate

    // Storage carries no reset so it maps onto a plain dual-port RAM.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            mem_q[wr_ptr_q] <= bus.din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign bus.dout         = dout_q;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (count_q >= c_afull);
    assign bus.almost_empty = (count_q <= c_aempty);
    assign bus.data_count   = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_sfifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfifo
// Brief    : Scoreboard bench driving a standard and a FWFT sfifo in lockstep
//            against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_sfifo;

    localparam int c_aw    = 4;
    localparam int c_dw    = 8;
    localparam int c_depth = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_en = 1'b0;
    logic            rd_en = 1'b0;
    logic [c_dw-1:0] din = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sfifo_if #(.DATA_W(c_dw), .ADDR_W(c_aw)) if_std ();
    sfifo_if #(.DATA_W(c_dw), .ADDR_W(c_aw)) if_fw ();

    assign if_std.din   = din;
    assign if_std.wr_en = wr_en;
    assign if_std.rd_en = rd_en;
    assign if_fw.din    = din;
    assign if_fw.wr_en  = wr_en;
    assign if_fw.rd_en  = rd_en;

    sfifo #(.DATA_W(c_dw), .ADDR_W(c_aw), .FWFT(1'b0), .AFULL_TH(12), .AEMPTY_TH(4))
        u_std (.clk(clk), .rst_n(rst_n), .bus(if_std));

    sfifo #(.DATA_W(c_dw), .ADDR_W(c_aw), .FWFT(1'b1), .AFULL_TH(12), .AEMPTY_TH(4))
        u_fw (.clk(clk), .rst_n(rst_n), .bus(if_fw));

    typedef struct packed {
        logic [4:0] count;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       udf;
        logic [7:0] d_std;
        logic [7:0] d_fw;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of stored words, evaluated once per edge.
    logic [7:0] mq[$];
    logic [7:0] m_d_std = '0;
    logic [7:0] m_d_fw  = '0;

    initial begin
        forever begin
            bit   wa, ra, ovf, udf;
            exp_t e;
            @(posedge clk);
            ovf = 1'b0;
            udf = 1'b0;
            if (!rst_n) begin
                mq.delete();
                m_d_std = '0;
                m_d_fw  = '0;
            end else begin
                wa  = wr_en && (mq.size() < c_depth);
                ra  = rd_en && (mq.size() > 0);
                ovf = wr_en && !wa;
                udf = rd_en && !ra;
                if (ra) m_d_std = mq.pop_front();
                if (wa) mq.push_back(din);
                if (mq.size() > 0) m_d_fw = mq[0];
            end
            e.count = 5'(mq.size());
            e.full  = (mq.size() == c_depth);
            e.empty = (mq.size() == 0);
            e.af    = (mq.size() >= 12);
            e.ae    = (mq.size() <= 4);
            e.ovf   = ovf;
            e.udf   = udf;
            e.d_std = m_d_std;
            e.d_fw  = m_d_fw;
            exp_q.push_back(e);
        end
    end

    // Monitor: compares both DUTs against the oldest pending expectation.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count_std", 32'(if_std.data_count), 32'(e.count));
                chk("count_fw",  32'(if_fw.data_count),  32'(e.count));
                chk("full_std",  32'(if_std.full),  32'(e.full));
                chk("full_fw",   32'(if_fw.full),   32'(e.full));
                chk("empty_std", 32'(if_std.empty), 32'(e.empty));
                chk("empty_fw",  32'(if_fw.empty),  32'(e.empty));
                chk("afull_std", 32'(if_std.almost_full),  32'(e.af));
                chk("afull_fw",  32'(if_fw.almost_full),   32'(e.af));
                chk("aempty_std", 32'(if_std.almost_empty), 32'(e.ae));
                chk("aempty_fw",  32'(if_fw.almost_empty),  32'(e.ae));
                chk("ovf_std",   32'(if_std.overflow),  32'(e.ovf));
                chk("ovf_fw",    32'(if_fw.overflow),   32'(e.ovf));
                chk("udf_std",   32'(if_std.underflow), 32'(e.udf));
                chk("udf_fw",    32'(if_fw.underflow),  32'(e.udf));
                chk("dout_std",  32'(if_std.dout), 32'(e.d_std));
                chk("dout_fw",   32'(if_fw.dout),  32'(e.d_fw));
            end
        end
    end

    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        @(negedge clk);
        #1;
        wr_en = w;
        rd_en = r;
        din   = d;
    endtask

    task automatic chk_reset_now();
        chk("rst_count_std", 32'(if_std.data_count), 32'd0);
        chk("rst_count_fw",  32'(if_fw.data_count),  32'd0);
        chk("rst_empty_std", 32'(if_std.empty), 32'd1);
        chk("rst_empty_fw",  32'(if_fw.empty),  32'd1);
        chk("rst_full_std",  32'(if_std.full),  32'd0);
        chk("rst_ae_std",    32'(if_std.almost_empty), 32'd1);
        chk("rst_af_std",    32'(if_std.almost_full),  32'd0);
        chk("rst_dout_std",  32'(if_std.dout), 32'd0);
        chk("rst_dout_fw",   32'(if_fw.dout),  32'd0);
        chk("rst_ovf_std",   32'(if_std.overflow),  32'd0);
        chk("rst_udf_std",   32'(if_std.underflow), 32'd0);
    endtask

    initial begin
        int pw, pr, budget;
        logic [7:0] seq;

        // Power-on reset.
        repeat (3) cyc(1'b0, 1'b0, 8'h00);
        chk_reset_now();
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Fill 0x00..0x0F, then one rejected write.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(i));
        cyc(1'b1, 1'b0, 8'h10);
        cyc(1'b0, 1'b0, 8'h00);

        // Drain all 16, then one rejected read.
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);

        // Single-word fall-through and pop.
        cyc(1'b1, 1'b0, 8'hA5);
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);

        // Sustained read+write at count 8 across pointer wrap.
        seq = 8'h20;
        for (int i = 0; i < 8; i++) begin cyc(1'b1, 1'b0, seq); seq++; end
        for (int i = 0; i < 40; i++) begin cyc(1'b1, 1'b1, seq); seq++; end
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'h00);

        // Both requests on empty, then on full.
        cyc(1'b1, 1'b1, 8'h77);
        cyc(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 8'(8'h80 + i));
        cyc(1'b1, 1'b1, 8'hEE);
        cyc(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 8'h00);

        // Reset in the middle of a write burst at count 9.
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i));
        @(negedge clk);
        #1;
        wr_en = 1'b1;
        din   = 8'hC9;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_now();
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h50 + i));
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 8'h00);

        // Randomised traffic with shifting bias to hit both ends.
        for (int blk = 0; blk < 4; blk++) begin
            case (blk)
                0:       begin pw = 75; pr = 30; end
                1:       begin pw = 25; pr = 80; end
                2:       begin pw = 90; pr = 90; end
                default: begin pw = 50; pr = 50; end
            endcase
            for (int i = 0; i < 120; i++) begin
                cyc(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr),
                    8'($urandom));
            end
        end

        cyc(1'b0, 1'b0, 8'h00);
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
